// File: rtl/pcs_receive.sv
// PCS receive stage for 1000BASE-X.
// Takes the Synchronizer's SUDI stream (rx_even plus a 10-bit code group), tracks
// idle / start / end / carrier-extend ordered sets, decodes 8b/10b data groups
// and drives a registered GMII-style receive interface toward the MAC.
// Every output is registered, so each code group shows up on RXD/RX_DV/RX_ER
// exactly one rx_clk after it is presented.
module pcs_receive #(
    parameter logic [7:0] PREAMBLE_BYTE = 8'h55,
    parameter bit         ER_ON_INVALID = 1'b1
) (
    input  logic       rx_clk,
    input  logic       reset,
    input  logic       sync_status,
    input  logic       rx_even,
    input  logic [9:0] rx_code_group,
    output logic [7:0] RXD,
    output logic       RX_DV,
    output logic       RX_ER,
    output logic       receiving
);

    // Special code groups, listed as {RD- form, RD+ form}; disparity is ignored.
    localparam logic [9:0] K28_5_NEG = 10'h0FA;
    localparam logic [9:0] K28_5_POS = 10'h305;
    localparam logic [9:0] K27_7_NEG = 10'h368;
    localparam logic [9:0] K27_7_POS = 10'h097;
    localparam logic [9:0] K29_7_NEG = 10'h2E8;
    localparam logic [9:0] K29_7_POS = 10'h117;
    localparam logic [9:0] K23_7_NEG = 10'h3A8;
    localparam logic [9:0] K23_7_POS = 10'h057;
    localparam logic [9:0] D16_2_POS = 10'h245;
    localparam logic [9:0] D16_2_NEG = 10'h1B5;
    localparam logic [9:0] D5_6      = 10'h296;

    // Carrier extend is reported as RXD=0x0F together with RX_ER and no RX_DV.
    localparam logic [7:0] CARRIER_EXTEND = 8'h0F;

    typedef enum logic [2:0] {
        LINK_FAILED,
        WAIT_FOR_K,
        RX_K,
        IDLE_D,
        RECEIVE,
        TRR
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [7:0] rxd_next;
    logic       rx_dv_next;
    logic       rx_er_next;
    logic       receiving_next;

    logic       is_comma;
    logic       is_start;
    logic       is_terminate;
    logic       is_carrier_ext;
    logic       is_idle_data;
    logic [5:0] dec_6b;
    logic [3:0] dec_4b;
    logic       data_valid;
    logic [7:0] data_byte;

    // 5b/6b sub-block decode: returns {valid, EDCBA}. Both disparity forms of
    // every data sub-block are listed; K28's 001111/110000 are deliberately
    // absent, so they come back invalid when seen as data.
    function automatic logic [5:0] decode_6b(input logic [5:0] abcdei);
        logic [5:0] result;
        case (abcdei)
            6'b100111, 6'b011000: result = {1'b1, 5'd0};
            6'b011101, 6'b100010: result = {1'b1, 5'd1};
            6'b101101, 6'b010010: result = {1'b1, 5'd2};
            6'b110001:            result = {1'b1, 5'd3};
            6'b110101, 6'b001010: result = {1'b1, 5'd4};
            6'b101001:            result = {1'b1, 5'd5};
            6'b011001:            result = {1'b1, 5'd6};
            6'b111000, 6'b000111: result = {1'b1, 5'd7};
            6'b111001, 6'b000110: result = {1'b1, 5'd8};
            6'b100101:            result = {1'b1, 5'd9};
            6'b010101:            result = {1'b1, 5'd10};
            6'b110100:            result = {1'b1, 5'd11};
            6'b001101:            result = {1'b1, 5'd12};
            6'b101100:            result = {1'b1, 5'd13};
            6'b011100:            result = {1'b1, 5'd14};
            6'b010111, 6'b101000: result = {1'b1, 5'd15};
            6'b011011, 6'b100100: result = {1'b1, 5'd16};
            6'b100011:            result = {1'b1, 5'd17};
            6'b010011:            result = {1'b1, 5'd18};
            6'b110010:            result = {1'b1, 5'd19};
            6'b001011:            result = {1'b1, 5'd20};
            6'b101010:            result = {1'b1, 5'd21};
            6'b011010:            result = {1'b1, 5'd22};
            6'b111010, 6'b000101: result = {1'b1, 5'd23};
            6'b110011, 6'b001100: result = {1'b1, 5'd24};
            6'b100110:            result = {1'b1, 5'd25};
            6'b010110:            result = {1'b1, 5'd26};
            6'b110110, 6'b001001: result = {1'b1, 5'd27};
            6'b001110:            result = {1'b1, 5'd28};
            6'b101110, 6'b010001: result = {1'b1, 5'd29};
            6'b011110, 6'b100001: result = {1'b1, 5'd30};
            6'b101011, 6'b010100: result = {1'b1, 5'd31};
            default:              result = 6'b000000;
        endcase
        return result;
    endfunction

    // 3b/4b sub-block decode: returns {valid, HGF}. Both the primary x.7 and
    // the alternate A7 forms decode to 7; only 0000 and 1111 are invalid.
    function automatic logic [3:0] decode_4b(input logic [3:0] fghj);
        logic [3:0] result;
        case (fghj)
            4'b1011, 4'b0100:                   result = {1'b1, 3'd0};
            4'b1001:                            result = {1'b1, 3'd1};
            4'b0101:                            result = {1'b1, 3'd2};
            4'b1100, 4'b0011:                   result = {1'b1, 3'd3};
            4'b1101, 4'b0010:                   result = {1'b1, 3'd4};
            4'b1010:                            result = {1'b1, 3'd5};
            4'b0110:                            result = {1'b1, 3'd6};
            4'b1110, 4'b0001, 4'b0111, 4'b1000: result = {1'b1, 3'd7};
            default:                            result = 4'b0000;
        endcase
        return result;
    endfunction

    // Classify the incoming code group; the ordered-set matches take priority
    // over data decode because /S/, /T/ and /R/ also look like legal data.
    always_comb begin
        is_comma       = (rx_code_group == K28_5_NEG) || (rx_code_group == K28_5_POS);
        is_start       = (rx_code_group == K27_7_NEG) || (rx_code_group == K27_7_POS);
        is_terminate   = (rx_code_group == K29_7_NEG) || (rx_code_group == K29_7_POS);
        is_carrier_ext = (rx_code_group == K23_7_NEG) || (rx_code_group == K23_7_POS);
        is_idle_data   = (rx_code_group == D16_2_POS) || (rx_code_group == D16_2_NEG) ||
                         (rx_code_group == D5_6);
        dec_6b         = decode_6b(rx_code_group[9:4]);
        dec_4b         = decode_4b(rx_code_group[3:0]);
        data_valid     = dec_6b[5] && dec_4b[3];
        data_byte      = {dec_4b[2:0], dec_6b[4:0]};
    end

    // Next-state and next-output logic; loss of sync overrides everything.
    always_comb begin
        state_next     = state;
        rxd_next       = 8'h00;
        rx_dv_next     = 1'b0;
        rx_er_next     = 1'b0;
        receiving_next = 1'b0;

        if (!sync_status) begin
            state_next = LINK_FAILED;
        end else begin
            case (state)
                LINK_FAILED: begin
                    state_next = WAIT_FOR_K;
                end

                WAIT_FOR_K: begin
                    if (is_comma && rx_even) begin
                        state_next = RX_K;
                    end
                end

                RX_K: begin
                    if (is_idle_data) begin
                        state_next = IDLE_D;
                    end else begin
                        state_next = WAIT_FOR_K;
                    end
                end

                IDLE_D: begin
                    if (is_comma && rx_even) begin
                        state_next = RX_K;
                    end else if (is_start) begin
                        state_next     = RECEIVE;
                        rxd_next       = PREAMBLE_BYTE;
                        rx_dv_next     = 1'b1;
                        receiving_next = 1'b1;
                    end else begin
                        state_next = WAIT_FOR_K;
                    end
                end

                RECEIVE: begin
                    if (is_terminate) begin
                        state_next = TRR;
                    end else if (is_comma) begin
                        state_next = RX_K;
                        rx_er_next = 1'b1;
                    end else if (is_start || is_carrier_ext || !data_valid) begin
                        rx_dv_next     = 1'b1;
                        rx_er_next     = ER_ON_INVALID;
                        receiving_next = 1'b1;
                    end else begin
                        rxd_next       = data_byte;
                        rx_dv_next     = 1'b1;
                        receiving_next = 1'b1;
                    end
                end

                TRR: begin
                    if (is_carrier_ext) begin
                        rxd_next   = CARRIER_EXTEND;
                        rx_er_next = 1'b1;
                    end else if (is_comma && rx_even) begin
                        state_next = RX_K;
                    end else begin
                        state_next = WAIT_FOR_K;
                    end
                end

                default: begin
                    state_next = LINK_FAILED;
                end
            endcase
        end
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge rx_clk or negedge reset) begin
        if (!reset) begin
            state     <= LINK_FAILED;
            RXD       <= 8'h00;
            RX_DV     <= 1'b0;
            RX_ER     <= 1'b0;
            receiving <= 1'b0;
        end else begin
            state     <= state_next;
            RXD       <= rxd_next;
            RX_DV     <= rx_dv_next;
            RX_ER     <= rx_er_next;
            receiving <= receiving_next;
        end
    end

endmodule

// File: doc/pcs_receive.md
Name: pcs_receive

Overview:
- PCS receive stage of the 1000BASE-X PCS. It sits directly downstream of the Synchronizer and consumes its SUDI stream (rx_even plus the 10-bit code group) and its sync_status.
- It recognises idle, start, end and carrier-extend ordered sets. It decodes 8b/10b data groups to bytes and drives a GMII-style receive interface (RXD/RX_DV/RX_ER) toward the MAC.
- All outputs are registered.

Parameters:
- PREAMBLE_BYTE, 8'h55: value driven on RXD in place of /S/.
- ER_ON_INVALID, 1: when 1, an invalid code group inside a frame asserts RX_ER; when 0, it is silently passed as RXD=8'h00.

Ports:
- rx_clk  input  1  receive clock; same clock as the Synchronizer.
- reset  input  1  asynchronous, active-low reset.
- sync_status  input  1  Synchronizer lock indication.
- rx_even  input  1  SUDI even flag; 1 = code group sits in an even position.
- rx_code_group  input  10  SUDI code group; bit 9 = 'a' (first bit on the wire), bit 0 = 'j'.
- RXD  output  8  decoded receive byte.
- RX_DV  output  1  receive data valid.
- RX_ER  output  1  receive error.
- receiving  output  1  high while a frame is in progress.

Behaviour:
- Reset (asynchronous, reset=0):
  - State goes to LINK_FAILED.
  - RXD=8'h00, RX_DV=0, RX_ER=0, receiving=0.
- Latency: exactly one rx_clk from a code group on rx_code_group to the corresponding RXD/RX_DV/RX_ER.
- Code-group classes, matched in either disparity:
  - K28.5 = 0x0FA / 0x305.
  - /S/ K27.7 = 0x368 / 0x097.
  - /T/ K29.7 = 0x2E8 / 0x117.
  - /R/ K23.7 = 0x3A8 / 0x057.
  - Idle data: D16.2 = 0x245 / 0x1B5, D5.6 = 0x296.
  - Data: abcdei is decoded to EDCBA via the full 5b/6b table; fghj is decoded to HGF via the 3b/4b table (including the D.x.A7 forms). Byte = {HGF, EDCBA}.
  - Any sub-block absent from the tables is INVALID. Running disparity is not checked.
- State machine (next-state evaluated every rx_clk):
  - LINK_FAILED:
    - RX_DV=0, RX_ER=0, receiving=0.
    - sync_status=1 -> WAIT_FOR_K.
  - WAIT_FOR_K:
    - Outputs idle.
    - K28.5 with rx_even=1 -> RX_K.
  - RX_K:
    - Outputs idle.
    - D16.2 or D5.6 -> IDLE_D.
    - Anything else -> WAIT_FOR_K.
  - IDLE_D:
    - K28.5 with rx_even=1 -> RX_K.
    - /S/ -> RECEIVE; emit RXD=PREAMBLE_BYTE, RX_DV=1, receiving=1.
    - Anything else -> WAIT_FOR_K.
  - RECEIVE:
    - Valid data: RXD=decoded byte, RX_DV=1.
    - /T/: RX_DV=0, RX_ER=0 -> TRR.
    - INVALID or unexpected K (/S/, /R/): RX_DV=1, RX_ER=ER_ON_INVALID, RXD=8'h00; stay in RECEIVE.
    - K28.5 (early end): RX_DV=0, RX_ER=1 for that one cycle, receiving=0 -> RX_K.
  - TRR:
    - RX_DV=0, receiving=0.
    - /R/: stay; RX_ER=1, RXD=8'h0F (carrier extend).
    - K28.5 with rx_even=1 -> RX_K.
    - Else -> WAIT_FOR_K.
- Loss of sync: sync_status=0 in any state forces LINK_FAILED on the next edge. It has priority over all other transitions, clears RX_DV and receiving, and leaves RX_ER=0.
- RX_DV and receiving never assert in LINK_FAILED, WAIT_FOR_K or RX_K.
- Back-to-back frames, i.e. /T/ /R/ K28.5 D16.2 /S/, must be accepted with no extra idle.

Test Plan:
- Lock-up, idle: assert sync_status, then feed 0x0FA (even) and 0x1B5 alternately -> state reaches IDLE_D; RX_DV=0, RX_ER=0, RXD=0x00 throughout.
- Frame: after idle, feed 0x368, 0x274, 0x2AA, 0x2E8, 0x3A8, 0x0FA (even), 0x245 -> RXD = 0x55, 0x00, 0xB5 with RX_DV=1 one cycle after each input. RX_DV drops on the /T/ cycle; the /R/ cycle gives RX_ER=1 with RXD=0x0F; receiving is 1 for exactly 3 cycles.
- Invalid in frame: feed 0x3FF between two data groups -> that cycle shows RX_DV=1, RX_ER=1, RXD=0x00; the next data byte is decoded normally.
- Early end: feed /S/, 0x274, then 0x0FA (even) -> cycle 3 shows RX_DV=0, RX_ER=1; the following D16.2 returns to IDLE_D.
- Sync loss mid-frame: drop sync_status during RECEIVE -> the next cycle shows RX_DV=0, receiving=0, RX_ER=0. Relocking requires K28.5 (even) followed by D16.2 before any /S/ is honoured.
- Async reset mid-frame: pulse reset=0 between rx_clk edges -> all outputs go to 0 immediately without waiting for an edge; state is LINK_FAILED.
